// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage with a single outstanding imem request,
//            IF/ID pipeline register, stall hold buffer and branch flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IF_IDWrite,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_buf;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;

    logic        w_accept;
    logic        w_outstanding;
    logic [31:0] w_pc_next;
    logic [31:0] w_target;

    // Request is gated by reset so nothing is issued while reset is held.
    assign imem_req  = reset && (r_state == S_REQ) && PCWrite;
    assign imem_addr = r_pc;

    assign w_accept  = imem_req && imem_ready;
    assign w_pc_next = r_pc + 32'd4;
    assign w_target  = {Branch_Target[31:2], 2'b00};

    // A fetch still in flight after this edge, with no response seen now.
    assign w_outstanding = ((r_state == S_WAIT) && !imem_rvalid) ||
                           ((r_state == S_DROP) && !imem_rvalid) ||
                           ((r_state == S_REQ)  && w_accept);

    assign IF_ID_PC    = r_ifid_pc;
    assign IF_ID_Instr = r_ifid_instr;
    assign IF_ID_Valid = r_ifid_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_hold_buf   <= 32'd0;
            r_ifid_pc    <= 32'd0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (Branch_Taken) begin
            r_pc         <= w_target;
            r_hold_buf   <= 32'd0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            r_state      <= w_outstanding ? S_DROP : S_REQ;
        end else begin
            // Default bubble when IF/ID is writable; deliveries override it.
            if (IF_IDWrite) begin
                r_ifid_instr <= NOP_INSTR;
                r_ifid_valid <= 1'b0;
            end

            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (IF_IDWrite) begin
                            r_ifid_pc    <= r_pc;
                            r_ifid_instr <= imem_rdata;
                            r_ifid_valid <= 1'b1;
                            r_pc         <= w_pc_next;
                            r_state      <= S_REQ;
                        end else begin
                            r_hold_buf   <= imem_rdata;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (IF_IDWrite) begin
                        r_ifid_pc    <= r_pc;
                        r_ifid_instr <= r_hold_buf;
                        r_ifid_valid <= 1'b1;
                        r_hold_buf   <= 32'd0;
                        r_pc         <= w_pc_next;
                        r_state      <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded at reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the instruction word driven on IF_ID_Instr whenever IF_ID_Valid=0.
REQ-003 clk  input  1  the single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
REQ-005 PCWrite  input  1  from hazard detection; 0 SHALL block issue of a new fetch request.
REQ-006 IF_IDWrite  input  1  from hazard detection; 0 SHALL freeze the IF/ID outputs.
REQ-007 Branch_Taken  input  1  redirect/flush request, one-cycle pulse.
REQ-008 Branch_Target  input  32  redirect address, valid when Branch_Taken=1.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address, equal to the PC register.
REQ-011 imem_ready  input  1  request accepted when imem_req && imem_ready.
REQ-012 imem_rvalid  input  1  response valid, at least 1 cycle after acceptance.
REQ-013 imem_rdata  input  32  response instruction word.
REQ-014 IF_ID_PC  output  32  PC of instruction in IF/ID.
REQ-015 IF_ID_Instr  output  32  instruction in IF/ID.
REQ-016 IF_ID_Valid  output  1  IF/ID holds a real instruction.

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD, DROP; at most one fetch outstanding at any time.
REQ-018 REQ: imem_req = PCWrite; on imem_req && imem_ready -> WAIT; otherwise stay in REQ.
REQ-019 WAIT: on imem_rvalid with IF_IDWrite=1, the block SHALL load IF/ID = {PC, imem_rdata, Valid=1} and set PC <= PC+4 -> REQ.
REQ-020 WAIT: on imem_rvalid with IF_IDWrite=0, imem_rdata SHALL be captured in an internal hold buffer -> HOLD; PC unchanged.
REQ-021 HOLD: imem_req=0; when IF_IDWrite=1, IF/ID SHALL load {PC, buffer, 1} and PC <= PC+4 -> REQ.
REQ-022 When IF_IDWrite=1 and no instruction is delivered that cycle, IF_ID_Valid SHALL go 0 next cycle (bubble); IF_ID_PC is don't-care.
REQ-023 When IF_IDWrite=0 and there is no flush, IF_ID_PC/Instr/Valid SHALL hold their values.
REQ-024 PC+4 SHALL be 32-bit modular: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-025 Branch_Taken=1 SHALL take priority over IF_IDWrite/PCWrite: IF_ID_Valid <= 0, hold buffer discarded, PC <= {Branch_Target[31:2], 2'b00}.
REQ-026 Flush next state: if a fetch is outstanding after this edge with no response this cycle (WAIT without rvalid, or REQ accepted this cycle) -> DROP; otherwise -> REQ.
REQ-027 A response arriving in the same cycle as a flush SHALL be discarded.
REQ-028 DROP: imem_req=0; the next imem_rvalid SHALL be discarded -> REQ; a further Branch_Taken in DROP SHALL update PC and remain in DROP.
REQ-029 imem_rvalid in REQ or HOLD is a protocol error and SHALL be ignored.
REQ-030 Nothing in IF/ID or PC SHALL change on an imem response combinationally; all updates occur on the clk edge.

Reset
REQ-031 While reset=0: PC=RESET_PC, state=REQ, IF_ID_Valid=0, IF_ID_PC=0, IF_ID_Instr=NOP_INSTR, hold buffer cleared, imem_req=0.
REQ-032 Reset asserted mid-fetch SHALL abandon the outstanding request; a later stale imem_rvalid in REQ SHALL be ignored per REQ-029.
REQ-033 First imem_req=1 SHALL occur in the first cycle after reset deasserts, with imem_addr=RESET_PC, provided PCWrite=1.

Verification
REQ-034 Streaming: ready=1, 1-cycle rvalid, rdata=addr^32'hA5A5_A5A5 -> IF_ID_PC sequence 0,4,8,... with matching Instr, Valid=1 on every delivery cycle.
REQ-035 Stall: IF_IDWrite=0 and PCWrite=0 for 3 cycles when rvalid arrives for PC=8 -> IF/ID holds PC=4 for 3 cycles, then PC=8 loads from the buffer; no extra imem_req issued.
REQ-036 Flush in WAIT: Branch_Taken with Target=32'h0000_0103 while a fetch of 0x10 is outstanding -> rdata for 0x10 dropped, next imem_addr=0x100, IF_ID_Valid=0 until 0x100 is delivered.
REQ-037 Flush with simultaneous rvalid and IF_IDWrite=0 -> response discarded, Valid=0, next imem_addr=target.
REQ-038 Wrap: RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0.
REQ-039 Reset pulse while in WAIT -> outputs at reset values, stale rvalid ignored, fetch restarts at RESET_PC.
